// File: rtl/data_mem_bus.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_bus
//  Purpose  : Data-side responder for a single-cycle core. Decodes each word
//             address into a word-addressed RAM, a few memory-mapped
//             registers (LED, CYCLES counter) and a byte-wide transmit FIFO.
//             Loads are combinational. Every state change happens on the
//             rising clock edge.
//  Ports    : clk, reset      - clock and synchronous active-high reset
//             Addr, WriteData - byte address / store data from the core
//             MemWrite        - store strobe
//             ReadData        - combinational load data
//             LED             - LED register contents
//             TxValid, TxData - FIFO head handshake toward the transmitter
//             TxReady         - transmitter accepts TxData this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_bus #(
    parameter int unsigned RAM_WORDS = 64,
    parameter int unsigned TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [31:0] LED,
    output logic        TxValid,
    output logic [7:0]  TxData,
    input  logic        TxReady
);

    localparam int unsigned c_RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned c_PW     = $clog2(TX_DEPTH);
    localparam int unsigned c_CW     = c_PW + 1;

    localparam logic [29:0] c_WA_LED   = 30'h0000_0400;  // 0x1000 >> 2
    localparam logic [29:0] c_WA_CYC   = 30'h0000_0401;  // 0x1004 >> 2
    localparam logic [29:0] c_WA_TXDAT = 30'h0000_0402;  // 0x1008 >> 2
    localparam logic [29:0] c_WA_TXCLR = 30'h0000_0403;  // 0x100C >> 2

    // Byte offset bits are meaningless: every access is a full word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Addr[1:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]     mem_q [RAM_WORDS];
    logic [7:0]      fifo_q [TX_DEPTH];
    logic [31:0]     led_q,    led_d;
    logic [31:0]     cyc_q,    cyc_d;
    logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_CW-1:0] count_q,  count_d;
    logic            ovf_q,    ovf_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [29:0]         w_word;
    logic                w_sel_ram;
    logic                w_sel_led;
    logic                w_sel_cyc;
    logic                w_sel_txdat;
    logic                w_sel_txclr;
    logic [c_RAM_AW-1:0] w_ram_idx;

    assign w_word      = Addr[31:2];
    assign w_sel_ram   = (Addr[31:c_RAM_AW+2] == '0);
    assign w_sel_led   = (w_word == c_WA_LED);
    assign w_sel_cyc   = (w_word == c_WA_CYC);
    assign w_sel_txdat = (w_word == c_WA_TXDAT);
    assign w_sel_txclr = (w_word == c_WA_TXCLR);
    assign w_ram_idx   = Addr[c_RAM_AW+1:2];

    // ------------------------------------------------------------------
    // FIFO handshake
    // ------------------------------------------------------------------
    logic w_full, w_empty, w_push, w_pop, w_push_ok;

    assign w_full    = (count_q == c_CW'(TX_DEPTH));
    assign w_empty   = (count_q == '0);
    assign w_pop     = !w_empty && TxReady;
    assign w_push    = MemWrite && w_sel_txdat;
    // A push into a full FIFO only fits if the head leaves in the same cycle.
    assign w_push_ok = w_push && (!w_full || w_pop);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        led_d    = led_q;
        cyc_d    = cyc_q + 32'd1;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (MemWrite && w_sel_led) led_d = WriteData;
        // A store to the counter wins over the increment.
        if (MemWrite && w_sel_cyc) cyc_d = WriteData;

        if (w_pop)     rd_ptr_d = rd_ptr_q + c_PW'(1);
        if (w_push_ok) wr_ptr_d = wr_ptr_q + c_PW'(1);

        if (w_push_ok && !w_pop)      count_d = count_q + c_CW'(1);
        else if (!w_push_ok && w_pop) count_d = count_q - c_CW'(1);

        if (MemWrite && w_sel_txclr)       ovf_d = 1'b0;
        else if (w_push && w_full && !w_pop) ovf_d = 1'b1;
    end

    // ------------------------------------------------------------------
    // Registers (FIFO storage is cleared too so TxData reads 0 after reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q    <= '0;
            cyc_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < int'(TX_DEPTH); i++) fifo_q[i] <= '0;
        end else begin
            led_q    <= led_d;
            cyc_q    <= cyc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            // When full with a simultaneous pop, wr_ptr equals rd_ptr: the
            // departing head is read this cycle and its slot becomes the tail.
            if (w_push_ok) fifo_q[wr_ptr_q] <= WriteData[7:0];
        end
    end

    // RAM contents are not reset; stores are still blocked during reset.
    always_ff @(posedge clk) begin
        if (!reset && MemWrite && w_sel_ram) mem_q[w_ram_idx] <= WriteData;
    end

    // ------------------------------------------------------------------
    // Load path (pre-edge state, no side effects)
    // ------------------------------------------------------------------
    logic [31:0] w_status;
    assign w_status = {24'd0, 4'(count_q), 1'b0, ovf_q, w_empty, w_full};

    always_comb begin
        ReadData = '0;
        if (w_sel_ram)        ReadData = mem_q[w_ram_idx];
        else if (w_sel_led)   ReadData = led_q;
        else if (w_sel_cyc)   ReadData = cyc_q;
        else if (w_sel_txdat) ReadData = w_status;
    end

    assign LED     = led_q;
    assign TxValid = !w_empty;
    assign TxData  = fifo_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: doc/data_mem_bus.md
# data_mem_bus

Memory-side responder for the single-cycle core's data port. It decodes each load/store address into one of three targets: a word-addressed data RAM, a small set of memory-mapped registers, and a byte-wide transmit FIFO that drains to an external serial transmitter. Loads complete combinationally within the same cycle, as the single-cycle datapath requires. Stores, register updates, counter updates and FIFO push/pop all take effect on the rising clock edge.

## Interface

Parameters:
- RAM_WORDS, 64: data RAM depth in 32-bit words. Power of two, 16..1024.
- TX_DEPTH, 4: transmit FIFO depth in bytes. Power of two, 2..8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Addr  input  32  byte address from the core (ALU result). Bits [1:0] are ignored and all accesses are word accesses.
- WriteData  input  32  store data from the core.
- MemWrite  input  1  store strobe, sampled at the clock edge.
- ReadData  output  32  load data. Combinational from Addr and current state.
- LED  output  32  LED register contents.
- TxValid  output  1  FIFO non-empty; TxData is valid.
- TxData  output  8  byte at the FIFO head.
- TxReady  input  1  downstream transmitter accepts TxData this cycle.

## Operation

Address map (decode on Addr[31:2]):
- 0x0000_0000 .. RAM_WORDS*4-1: RAM.
  - Read returns the word at index Addr[log2(RAM_WORDS)+1:2].
  - Write stores WriteData.
- 0x0000_1000 LEDREG: read/write 32-bit register driving LED.
- 0x0000_1004 CYCLES: free-running 32-bit counter.
  - Read returns the current value.
  - Write loads WriteData.
- 0x0000_1008 TXDATA:
  - Write pushes WriteData[7:0] into the FIFO.
  - Read returns status: bit0 = full, bit1 = empty, bit2 = overflow (sticky), bits[7:4] = occupancy, all other bits 0.
- 0x0000_100C TXCLR: any write clears the overflow bit. Reads return 0.
- Any other address: reads return 0 and writes are ignored with no side effects.

Reads never have side effects, because the core drives Addr every cycle whether or not it is executing a load.

CYCLES behaviour:
- Next value is CYCLES+1 and wraps 0xFFFF_FFFF -> 0.
- A write in the same cycle takes priority: next value = WriteData, not WriteData+1.

FIFO behaviour (circular buffer with read pointer, write pointer and occupancy count):
- Push: MemWrite with TXDATA address.
- Pop: TxValid && TxReady.
- Push while not full: accepted.
- Push while full with no pop in the same cycle: byte dropped, overflow set to 1, contents unchanged.
- Push and pop in the same cycle while full: both happen, count stays at TX_DEPTH, no overflow.
- Push and pop in the same cycle at any other count: count unchanged, the head advances and the new byte lands at the tail.
- Pop with count 0 cannot occur, since TxValid = 0.
- Pointers wrap modulo TX_DEPTH.
- A push to an empty FIFO makes TxValid = 1 in the following cycle with TxData equal to that byte (no bypass).

## Timing

Reset values, applied at the clock edge while reset = 1:
- LED = 0, CYCLES = 0, FIFO count and pointers = 0, overflow = 0.
- TxValid = 0, TxData = 0.
- RAM contents are not reset; they are undefined until written.
- Reset asserted mid-operation discards all queued FIFO bytes, and any store presented that cycle is ignored.

Latency and ordering:
- Load latency is 0 cycles: ReadData reflects pre-edge state.
- A store at edge N is visible to a load in cycle N+1. A load in the same cycle as a store to the same address returns the old value.
- The TXDATA status read reflects count and flags before the current cycle's push/pop.
- TxData is registered from FIFO storage: stable while TxValid = 1 and TxReady = 0.

## Test plan

- Reset, then store 0xDEADBEEF to 0x0000_0008, then load 0x0000_0008 -> ReadData = 0xDEADBEEF. Load 0x0000_000B -> same word. Load 0x0000_2000 -> 0.
- After reset, hold MemWrite = 0 for 10 cycles and read 0x1004 -> 10. Store 0xFFFF_FFFE to 0x1004 -> reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000.
- TxReady = 0; push 0x41, 0x42, 0x43, 0x44 -> status = 0x41 (full, count 4). Push 0x45 -> status = 0x45 and the FIFO still holds 41..44. Write 0x100C -> bit2 clears.
- From the full state, set TxReady = 1 for 4 cycles -> TxData sequence 0x41, 0x42, 0x43, 0x44, then TxValid = 0 and status = 0x02.
- Full FIFO with TxReady = 1 and a push of 0x55 in the same cycle -> count stays 4, no overflow, and 0x55 is the fourth byte out.
- Store 0x0000_00A5 to 0x1000 -> LED = 0xA5 next cycle. Assert reset with 2 bytes queued -> LED = 0, TxValid = 0, status = 0x02 the next cycle.
